// File: rtl/br_pkg.sv
// Shared constants and helpers for the banco_reg_mp register bank.
package br_pkg;

  localparam int unsigned BR_DATA_W = 32;
  localparam int unsigned BR_ADDR_W = 5;
  localparam int unsigned BR_NUM_RD = 2;
  localparam int unsigned REG_ZERO  = 0;

  // Widest flattened vector / field the slicing helper handles.
  localparam int unsigned BR_FLAT_W  = 256;
  localparam int unsigned BR_FIELD_W = 64;

  typedef logic [BR_FLAT_W-1:0]  br_flat_t;
  typedef logic [BR_FIELD_W-1:0] br_field_t;

  // Returns field idx of width w from a flattened port vector, zero-extended.
  function automatic br_field_t br_slice(input br_flat_t vec, input int unsigned idx,
                                         input int unsigned w);
    br_flat_t  shifted;
    br_field_t res;
    shifted = vec >> (idx * w);
    for (int unsigned b = 0; b < BR_FIELD_W; b++) begin
      res[b] = (b < w) ? shifted[b] : 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/banco_reg_mp_if.sv
// Operand/write/reservation bus of banco_reg_mp; master drives, bank (slave) answers.
interface banco_reg_mp_if
  import br_pkg::*;
#(
  parameter int unsigned DATA_W = BR_DATA_W,
  parameter int unsigned ADDR_W = BR_ADDR_W,
  parameter int unsigned NUM_RD = BR_NUM_RD
);
  logic [NUM_RD*ADDR_W-1:0] DL;
  logic [NUM_RD*DATA_W-1:0] op;
  logic [NUM_RD-1:0]        Ocup;
  logic                     WE;
  logic [ADDR_W-1:0]        Dir;
  logic [DATA_W-1:0]        Dato;
  logic                     RES;
  logic [ADDR_W-1:0]        DirRes;
  logic [ADDR_W:0]          NumOcup;

  modport master (
    output DL, WE, Dir, Dato, RES, DirRes,
    input  op, Ocup, NumOcup
  );

  modport slave (
    input  DL, WE, Dir, Dato, RES, DirRes,
    output op, Ocup, NumOcup
  );

endinterface

// File: rtl/br_scoreboard.sv
// Pending-write scoreboard: per-register busy bits plus a registered popcount.
module br_scoreboard
  import br_pkg::*;
#(
  parameter int unsigned ADDR_W   = BR_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      dir_i,
  input  logic                   res_i,
  input  logic [ADDR_W-1:0]      dir_res_i,
  output logic [(2**ADDR_W)-1:0] busy_o,
  output logic [ADDR_W:0]        num_ocup_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  logic [Depth-1:0] busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             we_v, res_v, inc, dec;

  always_comb begin
    we_v  = we_i && !(ZERO_REG && (dir_i == ADDR_W'(REG_ZERO)));
    res_v = res_i && !(ZERO_REG && (dir_res_i == ADDR_W'(REG_ZERO)));

    // Reservation applied last so a same-address new producer wins.
    busy_d = busy_q;
    if (we_v)  busy_d[dir_i] = 1'b0;
    if (res_v) busy_d[dir_res_i] = 1'b1;

    inc = res_v && !busy_q[dir_res_i];
    dec = we_v && busy_q[dir_i] && !(res_v && (dir_res_i == dir_i));

    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + CntW'(1);
    else if (dec && !inc) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign num_ocup_o = cnt_q;

endmodule

// File: rtl/banco_reg_mp.sv
// Multi-read-port register bank with pending-write scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining BR_BYPASS_EN.
module banco_reg_mp
  import br_pkg::*;
#(
  parameter int unsigned DATA_W   = BR_DATA_W,
  parameter int unsigned ADDR_W   = BR_ADDR_W,
  parameter int unsigned NUM_RD   = BR_NUM_RD,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic           CLK,
  input  logic           RST_N,
  banco_reg_mp_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [Depth];
  logic [Depth-1:0]         busy;
  logic [ADDR_W:0]          num_ocup;
  logic                     we_ok;
  logic [ADDR_W-1:0]        rd_addr [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] op_flat;
  logic [NUM_RD-1:0]        ocup_vec;

  assign we_ok = bus.WE && !(ZERO_REG && (bus.Dir == ADDR_W'(REG_ZERO)));

  br_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .we_i       (bus.WE),
    .dir_i      (bus.Dir),
    .res_i      (bus.RES),
    .dir_res_i  (bus.DirRes),
    .busy_o     (busy),
    .num_ocup_o (num_ocup)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < Depth; k++) mem_q[k] <= '0;
    end else if (we_ok) begin
      mem_q[bus.Dir] <= bus.Dato;
    end
  end

  always_comb begin
    op_flat  = '0;
    ocup_vec = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_addr[i] = ADDR_W'(br_slice(br_flat_t'(bus.DL), i, ADDR_W));
      op_flat[i*DATA_W +: DATA_W] = mem_q[rd_addr[i]];
      ocup_vec[i] = busy[rd_addr[i]];
      if (ZERO_REG && (rd_addr[i] == ADDR_W'(REG_ZERO))) begin
        op_flat[i*DATA_W +: DATA_W] = '0;
        ocup_vec[i] = 1'b0;
      end
`ifdef BR_BYPASS_EN
      // Forward the in-flight write; only a same-address re-reservation keeps it pending.
      if (we_ok && (rd_addr[i] == bus.Dir)) begin
        op_flat[i*DATA_W +: DATA_W] = bus.Dato;
        ocup_vec[i] = bus.RES && (bus.DirRes == bus.Dir);
      end
`else
      // Pre-edge state only; consumers see the write one cycle later.
`endif
    end
    // Bypass paths are combinational from inputs, so force quiet outputs in reset.
    if (!RST_N) begin
      op_flat  = '0;
      ocup_vec = '0;
    end
  end

  assign bus.op      = op_flat;
  assign bus.Ocup    = ocup_vec;
  assign bus.NumOcup = RST_N ? num_ocup : '0;

endmodule

// File: tb/tb_banco_reg_mp.sv
// Self-checking bench for banco_reg_mp: directed vector table plus reset/boundary sequences.
module tb_banco_reg_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
`ifdef BR_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  banco_reg_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  banco_reg_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1'b1)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] dir;
    logic [DW-1:0] dato;
    logic          res;
    logic [AW-1:0] dirres;
    logic [AW-1:0] dl0;
    logic [AW-1:0] dl1;
    logic [DW-1:0] op0;
    logic [DW-1:0] op1;
    logic          oc0;
    logic          oc1;
    logic [AW:0]   num;
    logic [DW-1:0] bop0;
    logic          boc0;
  } vec_t;

  vec_t vecs [12];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] dir, input logic [DW-1:0] dato,
                       input logic res, input logic [AW-1:0] dirres,
                       input logic [AW-1:0] dl0, input logic [AW-1:0] dl1);
    bus.WE     = we;
    bus.Dir    = dir;
    bus.Dato   = dato;
    bus.RES    = res;
    bus.DirRes = dirres;
    bus.DL     = {dl1, dl0};
  endtask

  initial begin
    //          we dir  dato          res dres dl0 dl1 op0           op1           o0 o1 num bop0          bo0
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'h0,        32'h0,        0, 0, 0, 32'hDEADBEEF, 0};
    vecs[1]  = '{0, 0, 32'h0,        0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0};
    vecs[2]  = '{1, 0, 32'h12345678, 1, 0, 0, 5, 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h0,        0};
    vecs[3]  = '{0, 0, 32'h0,        1, 7, 0, 7, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
    vecs[4]  = '{0, 0, 32'h0,        0, 0, 7, 0, 32'h0,        32'h0,        1, 0, 1, 32'h0,        1};
    vecs[5]  = '{1, 7, 32'hA5A5A5A5, 1, 7, 7, 0, 32'h0,        32'h0,        1, 0, 1, 32'hA5A5A5A5, 1};
    vecs[6]  = '{1, 7, 32'h11111111, 0, 0, 7, 0, 32'hA5A5A5A5, 32'h0,        1, 0, 1, 32'h11111111, 0};
    vecs[7]  = '{0, 0, 32'h0,        0, 0, 7, 0, 32'h11111111, 32'h0,        0, 0, 0, 32'h11111111, 0};
    vecs[8]  = '{1, 9, 32'h99,       1, 3, 9, 3, 32'h0,        32'h0,        0, 0, 0, 32'h99,       0};
    vecs[9]  = '{1, 3, 32'h33,       1, 4, 3, 4, 32'h0,        32'h0,        1, 0, 1, 32'h33,       0};
    vecs[10] = '{0, 0, 32'h0,        1, 4, 3, 4, 32'h33,       32'h0,        0, 1, 1, 32'h33,       0};
    vecs[11] = '{1, 4, 32'h44,       0, 0, 9, 3, 32'h99,       32'h33,       0, 0, 1, 32'h99,       0};

    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2 check("reset_num", 64'(bus.NumOcup), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, AW'(a), AW'(31 - a));
      #1;
      check($sformatf("rst_op0[%0d]", a), 64'(bus.op[DW-1:0]), 64'd0);
      check($sformatf("rst_op1[%0d]", 31 - a), 64'(bus.op[2*DW-1:DW]), 64'd0);
      check($sformatf("rst_ocup[%0d]", a), 64'(bus.Ocup), 64'd0);
    end
    check("rst_num_after", 64'(bus.NumOcup), 64'd0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].we, vecs[i].dir, vecs[i].dato, vecs[i].res, vecs[i].dirres,
            vecs[i].dl0, vecs[i].dl1);
      @(negedge clk);
      check($sformatf("v%0d_op0", i), 64'(bus.op[DW-1:0]), 64'(Byp ? vecs[i].bop0 : vecs[i].op0));
      check($sformatf("v%0d_op1", i), 64'(bus.op[2*DW-1:DW]), 64'(vecs[i].op1));
      check($sformatf("v%0d_oc0", i), 64'(bus.Ocup[0]), 64'(Byp ? vecs[i].boc0 : vecs[i].oc0));
      check($sformatf("v%0d_oc1", i), 64'(bus.Ocup[1]), 64'(vecs[i].oc1));
      check($sformatf("v%0d_num", i), 64'(bus.NumOcup), 64'(vecs[i].num));
      @(posedge clk);
      #1;
    end

    // Reserve r1..r3, then pull reset mid-cycle.
    for (int r = 1; r <= 3; r++) begin
      drive(0, 0, 0, 1, AW'(r), 7, 3);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 7, 3);
    #1;
    check("seq_num3", 64'(bus.NumOcup), 64'd3);
    check("seq_op7", 64'(bus.op[DW-1:0]), 64'h11111111);
    check("seq_oc3", 64'(bus.Ocup[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_num", 64'(bus.NumOcup), 64'd0);
    check("async_op0", 64'(bus.op[DW-1:0]), 64'd0);
    check("async_ocup", 64'(bus.Ocup), 64'd0);

    // Release away from an edge; first edge must do a normal write and reservation.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 12, 32'h0000000C, 1, 13, 12, 13);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 12, 13);
    #1;
    check("rel_op12", 64'(bus.op[DW-1:0]), 64'hC);
    check("rel_oc13", 64'(bus.Ocup[1]), 64'd1);
    check("rel_num", 64'(bus.NumOcup), 64'd1);

    // Fill the scoreboard: with ZERO_REG the count tops out at 31.
    for (int r = 1; r < 32; r++) begin
      drive(0, 0, 0, 1, AW'(r), 0, 31);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 1, 0, 0, 31);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 31);
    #1;
    check("full_num", 64'(bus.NumOcup), 64'd31);
    check("full_oc0", 64'(bus.Ocup[0]), 64'd0);
    check("full_oc31", 64'(bus.Ocup[1]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/banco_reg_mp.md
# banco_reg_mp

Parametrised, clocked register bank with a configurable number of read ports, one synchronous write port, an optional hardwired-zero register and a per-register pending-write scoreboard. It sits in the decode stage of the ISA datapath. It supplies operands to the ALU and flags operands whose producing instruction has not yet written back, so the control unit can stall.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, register 0 reads as zero and ignores writes/reservations when 1

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- DL  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- op  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- Ocup  out  NUM_RD  port i operand is pending (scoreboard busy)
- WE  in  1  write enable
- Dir  in  ADDR_W  write address
- Dato  in  DATA_W  write data
- RES  in  1  reserve request: mark DirRes as pending
- DirRes  in  ADDR_W  register being reserved by an issuing instruction
- NumOcup  out  ADDR_W+1  count of currently pending registers

## Operation
- Reset (RST_N low, asynchronous): all registers = 0, all busy bits = 0.
  - Outputs while in reset: op = 0, Ocup = 0, NumOcup = 0.
- Write: at the rising edge, mem[Dir] <= Dato when WE=1.
  - Suppressed when ZERO_REG=1 and Dir=0.
- Read: op[i] = mem[DL[i]], combinational.
  - Port i returns 0 when ZERO_REG=1 and DL[i]=0.
- Scoreboard, per register at each rising edge:
  - busy[DirRes] <= 1 when RES=1.
  - busy[Dir] <= 0 when WE=1.
  - RES and WE to the same address in the same cycle: busy ends at 1 (the new producer wins). The data write still occurs.
  - Register 0 is never busy when ZERO_REG=1.
- Ocup[i] = busy[DL[i]], combinational.
- NumOcup = population count of the busy bits, maintained as a registered counter.
  - +1 when a reservation sets a clear bit.
  - -1 when a write clears a set bit.
  - Unchanged when both occur on different addresses (+1 and -1 cancel), or when both target the same address.
  - A write to a non-busy register leaves the count unchanged.
  - Re-reserving an already-busy register leaves the count unchanged.
- Multiple read ports may address the same register; each returns identical data and Ocup.

## Timing
- Read latency: 0 cycles (combinational from DL).
- Write latency: data is visible on op the cycle after the WE edge, unless bypass is enabled.
- Scoreboard updates are visible on Ocup/NumOcup one edge after RES/WE.
- NumOcup never exceeds 2**ADDR_W (or 2**ADDR_W - 1 when ZERO_REG=1) and never goes below 0.
- Reset deasserted mid-operation: the first edge after release performs normal writes and reservations.

## Configuration
- BR_BYPASS_EN defined:
  - When WE=1 and Dir=DL[i] (excluding register 0 under ZERO_REG), op[i] = Dato in the same cycle.
  - In that same case Ocup[i] = 0, unless RES=1 with DirRes=Dir in the same cycle.
- BR_BYPASS_EN undefined:
  - op[i] and Ocup[i] show the pre-edge state.
  - The consumer sees the written value and the cleared busy bit one cycle later.

## Structure
- Package br_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants
  - the REG_ZERO address constant
  - a function to slice flattened port vectors
- Sub-module br_scoreboard holds:
  - the busy-bit vector
  - the set/clear priority logic
  - the NumOcup counter
- The top level instantiates br_scoreboard and holds the register array and read muxes.

## Test plan
- Reset then read all 32 addresses on both ports -> every op = 0, Ocup = 0, NumOcup = 0.
- WE=1, Dir=5, Dato=0xDEADBEEF; next cycle DL0=5 -> op0 = 0xDEADBEEF.
  - With BR_BYPASS_EN: op0 = 0xDEADBEEF during the write cycle.
  - Without BR_BYPASS_EN: op0 = 0 during the write cycle.
- WE=1, Dir=0, Dato=0x12345678 with ZERO_REG=1 -> op for DL=0 stays 0.
  - RES with DirRes=0 -> NumOcup stays 0.
- RES DirRes=7 -> Ocup=1 for DL=7, NumOcup=1.
  - Later, WE Dir=7 together with RES DirRes=7 -> busy stays 1, NumOcup=1.
  - Then WE Dir=7 alone -> Ocup=0, NumOcup=0.
- Reserve r1..r3 over 3 cycles -> NumOcup=3.
  - Then assert RST_N low mid-cycle -> NumOcup=0 and all op=0 immediately, without waiting for a clock edge.
